atm_controller_param: RTL and testbench
=======================================

# atm_controller_param

Parametrised ATM session controller: accepts a card, collects and checks a multi-digit PIN, then runs any number of deposit/withdrawal transactions against a loaded account balance until the customer ends the session or it times out. It is the next generation of the team's single-transaction ATM FSM and adds:

- generic PIN length and attempt count;
- a per-session withdrawal limit;
- an inactivity timeout;
- deposit saturation;
- an explicit card-eject handshake.

## Interface
- PIN_DIGITS, 4: digits per PIN.
- DIGIT_W, 4: bits per digit.
- MAX_INTENTOS, 3: wrong PIN entries that cause a block (≥2).
- BAL_W, 64: balance width.
- MONTO_W, 32: transaction amount width (≤ BAL_W).
- COMISION, 1000: fee charged to foreign cards at acceptance.
- LIMITE_RETIRO, 500000: maximum total withdrawn per session.
- TIMEOUT_CYC, 1024: idle cycles before a forced session end.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- tarjeta_recibida  in  1  card-present level.
- tipo_de_tarjeta  in  1  1 = foreign card (commission charged).
- balance_carga  in  BAL_W  account balance, sampled when the card is accepted.
- pin  in  PIN_DIGITS*DIGIT_W  stored PIN; first digit in the MSBs.
- digito  in  DIGIT_W  keyed digit.
- digito_stb  in  1  one-cycle strobe, digit valid.
- tipo_trans  in  1  0 = deposit, 1 = withdrawal; sampled with monto_stb.
- monto  in  MONTO_W  amount; sampled with monto_stb.
- monto_stb  in  1  one-cycle strobe, transaction request.
- fin_sesion  in  1  one-cycle strobe, customer ends the session.
- balance_out  out  BAL_W  current session balance, registered.
- balance_actualizado, entregar_dinero, fondos_insuficientes, limite_excedido, pin_incorrecto, expulsar_tarjeta  out  1 each  one-cycle pulses.
- advertencia, bloqueo  out  1 each  levels.

## Operation
- States: ESPERA_TARJETA, ESPERA_PIN, IDENTIFICADO, DEPOSITO, RETIRO, FIN, BLOQUEADO.
- Reset: state ESPERA_TARJETA. All outputs 0, balance_out 0. Digit counter, attempt counter, withdrawn total and timeout counter all 0.
- ESPERA_TARJETA: on tarjeta_recibida=1, load balance_carga.
  - Foreign card with balance_carga ≥ COMISION: deduct COMISION, go to ESPERA_PIN.
  - Foreign card with balance_carga < COMISION: pulse fondos_insuficientes and expulsar_tarjeta, stay in ESPERA_TARJETA.
  - Local card: no fee, go to ESPERA_PIN.
- ESPERA_PIN: each digito_stb shifts the digit into the entry register (LSB side) and increments the digit count.
  - On the strobe of digit PIN_DIGITS, compare the shifted value with pin. The count and entry register clear either way.
  - Match: go to IDENTIFICADO and clear the attempt counter.
  - Mismatch: pulse pin_incorrecto and increment the attempt counter.
  - When the counter reaches MAX_INTENTOS−1, advertencia rises and stays high.
  - When the counter reaches MAX_INTENTOS, go to BLOQUEADO.
- IDENTIFICADO: fin_sesion goes to FIN. Otherwise monto_stb latches monto and tipo_trans, then goes to DEPOSITO (tipo_trans=0) or RETIRO (tipo_trans=1). fin_sesion wins over a simultaneous monto_stb.
- DEPOSITO (one cycle): balance = balance+monto, saturating at 2^BAL_W−1. Pulse balance_actualizado, return to IDENTIFICADO.
- RETIRO (one cycle):
  - If monto > balance: pulse fondos_insuficientes.
  - Else if withdrawn+monto > LIMITE_RETIRO: pulse limite_excedido.
  - Otherwise subtract monto, add it to withdrawn, and pulse balance_actualizado and entregar_dinero.
  - monto == balance is allowed. monto=0 pulses balance_actualizado only.
  - Always return to IDENTIFICADO.
- FIN (one cycle): pulse expulsar_tarjeta; clear advertencia, withdrawn and counters; go to ESPERA_TARJETA. balance_out holds its last value.
- BLOQUEADO: bloqueo=1. Exits only on reset; all strobes are ignored.
- Timeout: the counter runs in ESPERA_PIN and IDENTIFICADO. It clears on any digito_stb or monto_stb and on every state entry. On reaching TIMEOUT_CYC−1 the FSM goes to FIN.
- Strobes arriving in states that do not consume them are ignored. tarjeta_recibida is ignored outside ESPERA_TARJETA.
- Arithmetic: monto is zero-extended to BAL_W. The withdrawn total is BAL_W wide.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Edge numbering: strobe sampled at edge E0, state update at E0.
- Digit that completes the PIN at E0: pin_incorrecto is high, or the state is IDENTIFICADO, in the cycle after E0.
- monto_stb at E0: execution state during cycle E0→E1; pulses and the new balance_out appear in cycle E1→E2; the next monto_stb is accepted from cycle E1→E2.
- Pulses last exactly one cycle.
- reset asserted mid-session: at the next edge, return to reset values regardless of state, including BLOQUEADO.

## Test plan
- Local card, balance_carga=5000, PIN 1-2-3-4 correct, deposit 300 → balance_out=5300, balance_actualizado pulses 1 cycle.
- Foreign card, balance_carga=3000 → balance_out=2000; withdraw 2000 (equal to balance) → entregar_dinero, balance_out=0; withdraw 1 → fondos_insuficientes.
- Three wrong PINs (MAX_INTENTOS=3) → pin_incorrecto pulses ×3, advertencia after the 2nd, bloqueo after the 3rd; a later correct PIN is ignored; reset clears all.
- LIMITE_RETIRO=500, balance 10000: withdraw 400 ok, withdraw 200 → limite_excedido, balance_out stays 9600.
- Identified, no strobes for TIMEOUT_CYC cycles → expulsar_tarjeta pulse, state ESPERA_TARJETA; fin_sesion together with monto_stb → eject, no transaction.
- Deposit driving balance past 2^BAL_W−1 (BAL_W=8, balance 250, deposit 10) → balance_out=255.

Source files
------------

// File: rtl/atm_controller_param_if.sv
// Customer-facing signals of the ATM session controller, grouped for one port.
interface atm_controller_param_if #(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int BAL_W      = 64,
  parameter int MONTO_W    = 32
);
  logic                          tarjeta_recibida;
  logic                          tipo_de_tarjeta;
  logic [BAL_W-1:0]              balance_carga;
  logic [PIN_DIGITS*DIGIT_W-1:0] pin;
  logic [DIGIT_W-1:0]            digito;
  logic                          digito_stb;
  logic                          tipo_trans;
  logic [MONTO_W-1:0]            monto;
  logic                          monto_stb;
  logic                          fin_sesion;
  logic [BAL_W-1:0]              balance_out;
  logic                          balance_actualizado;
  logic                          entregar_dinero;
  logic                          fondos_insuficientes;
  logic                          limite_excedido;
  logic                          pin_incorrecto;
  logic                          expulsar_tarjeta;
  logic                          advertencia;
  logic                          bloqueo;

  modport master (
    output tarjeta_recibida, tipo_de_tarjeta, balance_carga, pin, digito, digito_stb,
           tipo_trans, monto, monto_stb, fin_sesion,
    input  balance_out, balance_actualizado, entregar_dinero, fondos_insuficientes,
           limite_excedido, pin_incorrecto, expulsar_tarjeta, advertencia, bloqueo
  );

  modport slave (
    input  tarjeta_recibida, tipo_de_tarjeta, balance_carga, pin, digito, digito_stb,
           tipo_trans, monto, monto_stb, fin_sesion,
    output balance_out, balance_actualizado, entregar_dinero, fondos_insuficientes,
           limite_excedido, pin_incorrecto, expulsar_tarjeta, advertencia, bloqueo
  );
endinterface

// File: rtl/atm_controller_param.sv
// ATM session FSM: card acceptance, PIN check, repeated deposit/withdrawal, timeout.
// All outputs registered; a transaction shows its result two cycles after monto_stb.
module atm_controller_param #(
  parameter int          PIN_DIGITS    = 4,
  parameter int          DIGIT_W       = 4,
  parameter int          MAX_INTENTOS  = 3,
  parameter int          BAL_W         = 64,
  parameter int          MONTO_W       = 32,
  parameter int unsigned COMISION      = 1000,
  parameter int unsigned LIMITE_RETIRO = 500000,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input logic                   clk,
  input logic                   reset,
  atm_controller_param_if.slave bus
);
  localparam int PIN_W = PIN_DIGITS * DIGIT_W;
  localparam int DG_W  = $clog2(PIN_DIGITS + 1);
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int LW    = (BAL_W + 1 > 33) ? BAL_W + 1 : 33;

  typedef enum logic [2:0] {
    ESPERA_TARJETA, ESPERA_PIN, IDENTIFICADO, DEPOSITO, RETIRO, FIN, BLOQUEADO
  } estado_t;

  estado_t            estado;
  logic [PIN_W-1:0]   entrada;
  logic [DG_W-1:0]    n_dig;
  logic [INT_W-1:0]   intentos;
  logic [BAL_W-1:0]   retirado;
  logic [TMO_W-1:0]   inactivo;
  logic [MONTO_W-1:0] monto_q;
  logic [BAL_W-1:0]   balance_q;
  logic act_q, ent_q, fi_q, le_q, pi_q, ej_q, adv_q, blq_q;

  logic [PIN_W-1:0] entrada_sig;
  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;
  logic [LW-1:0]    retiro_total;
  logic [BAL_W-1:0] carga_neta;
  logic [INT_W-1:0] intentos_sig;
  logic             carga_ok;
  logic             tmo_fin;

  // Digits enter on the LSB side, so the first digit keyed ends up in the MSBs.
  assign entrada_sig  = PIN_W'({entrada, bus.digito});
  assign monto_ext    = BAL_W'(monto_q);
  assign suma         = {1'b0, balance_q} + {1'b0, monto_ext};
  assign retiro_total = LW'(retirado) + LW'(monto_ext);
  assign carga_neta   = bus.balance_carga - BAL_W'(COMISION);
  assign carga_ok     = LW'(bus.balance_carga) >= LW'(COMISION);
  assign intentos_sig = intentos + INT_W'(1);
  assign tmo_fin      = inactivo == TMO_W'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= ESPERA_TARJETA;
      entrada   <= '0;
      n_dig     <= '0;
      intentos  <= '0;
      retirado  <= '0;
      inactivo  <= '0;
      monto_q   <= '0;
      balance_q <= '0;
      act_q     <= 1'b0;
      ent_q     <= 1'b0;
      fi_q      <= 1'b0;
      le_q      <= 1'b0;
      pi_q      <= 1'b0;
      ej_q      <= 1'b0;
      adv_q     <= 1'b0;
      blq_q     <= 1'b0;
    end else begin
      act_q <= 1'b0;
      ent_q <= 1'b0;
      fi_q  <= 1'b0;
      le_q  <= 1'b0;
      pi_q  <= 1'b0;
      ej_q  <= 1'b0;
      case (estado)
        ESPERA_TARJETA: begin
          if (bus.tarjeta_recibida) begin
            inactivo <= '0;
            if (bus.tipo_de_tarjeta && !carga_ok) begin
              balance_q <= bus.balance_carga;
              fi_q      <= 1'b1;
              ej_q      <= 1'b1;
            end else begin
              balance_q <= bus.tipo_de_tarjeta ? carga_neta : bus.balance_carga;
              estado    <= ESPERA_PIN;
            end
          end
        end
        ESPERA_PIN: begin
          if (bus.digito_stb) begin
            inactivo <= '0;
            if (n_dig == DG_W'(PIN_DIGITS - 1)) begin
              n_dig   <= '0;
              entrada <= '0;
              if (entrada_sig == bus.pin) begin
                estado   <= IDENTIFICADO;
                intentos <= '0;
              end else begin
                pi_q     <= 1'b1;
                intentos <= intentos_sig;
                if (intentos_sig == INT_W'(MAX_INTENTOS - 1)) adv_q <= 1'b1;
                if (intentos_sig == INT_W'(MAX_INTENTOS)) begin
                  estado <= BLOQUEADO;
                  blq_q  <= 1'b1;
                end
              end
            end else begin
              n_dig   <= n_dig + DG_W'(1);
              entrada <= entrada_sig;
            end
          end else if (bus.monto_stb) begin
            inactivo <= '0;
          end else if (tmo_fin) begin
            estado   <= FIN;
            inactivo <= '0;
          end else begin
            inactivo <= inactivo + TMO_W'(1);
          end
        end
        IDENTIFICADO: begin
          if (bus.fin_sesion) begin
            estado   <= FIN;
            inactivo <= '0;
          end else if (bus.monto_stb) begin
            monto_q  <= bus.monto;
            estado   <= bus.tipo_trans ? RETIRO : DEPOSITO;
            inactivo <= '0;
          end else if (bus.digito_stb) begin
            inactivo <= '0;
          end else if (tmo_fin) begin
            estado   <= FIN;
            inactivo <= '0;
          end else begin
            inactivo <= inactivo + TMO_W'(1);
          end
        end
        DEPOSITO: begin
          balance_q <= suma[BAL_W] ? {BAL_W{1'b1}} : suma[BAL_W-1:0];
          act_q     <= 1'b1;
          estado    <= IDENTIFICADO;
        end
        RETIRO: begin
          if (monto_ext > balance_q) begin
            fi_q <= 1'b1;
          end else if (retiro_total > LW'(LIMITE_RETIRO)) begin
            le_q <= 1'b1;
          end else begin
            balance_q <= balance_q - monto_ext;
            retirado  <= retirado + monto_ext;
            act_q     <= 1'b1;
            ent_q     <= (monto_q != '0);
          end
          estado <= IDENTIFICADO;
        end
        FIN: begin
          ej_q     <= 1'b1;
          adv_q    <= 1'b0;
          retirado <= '0;
          intentos <= '0;
          n_dig    <= '0;
          entrada  <= '0;
          inactivo <= '0;
          estado   <= ESPERA_TARJETA;
        end
        BLOQUEADO: ;
        default: estado <= ESPERA_TARJETA;
      endcase
    end
  end

  assign bus.balance_out          = balance_q;
  assign bus.balance_actualizado  = act_q;
  assign bus.entregar_dinero      = ent_q;
  assign bus.fondos_insuficientes = fi_q;
  assign bus.limite_excedido      = le_q;
  assign bus.pin_incorrecto       = pi_q;
  assign bus.expulsar_tarjeta     = ej_q;
  assign bus.advertencia          = adv_q;
  assign bus.bloqueo              = blq_q;
endmodule

// File: tb/tb_atm_controller_param.sv
// Three differently sized controllers share one stimulus stream; each is compared every cycle to its own session model.
module tb_atm_controller_param;
  localparam int TMO = 40;
  localparam int F_UPD = 7, F_DN = 6, F_FI = 5, F_LE = 4, F_PI = 3, F_EJ = 2, F_ADV = 1, F_BLK = 0;
  localparam int P_CARD = 0, P_PIN = 1, P_ID = 2, P_DEP = 3, P_RET = 4, P_FIN = 5, P_BLK = 6;

  logic clk, reset;
  logic card, foreign, dstb, tt, mstb, fin;
  logic [63:0] carga;
  logic [3:0]  dig;
  logic [31:0] amt;
  logic [15:0] pin;
  int checks = 0, errors = 0;
  bit cmp_en = 0;

  atm_controller_param_if #(.PIN_DIGITS(4), .DIGIT_W(4), .BAL_W(64), .MONTO_W(32)) ifa();
  atm_controller_param_if #(.PIN_DIGITS(4), .DIGIT_W(4), .BAL_W(16), .MONTO_W(16)) ifb();
  atm_controller_param_if #(.PIN_DIGITS(4), .DIGIT_W(4), .BAL_W(8),  .MONTO_W(8))  ifc();

  atm_controller_param #(.PIN_DIGITS(4), .DIGIT_W(4), .MAX_INTENTOS(3), .BAL_W(64), .MONTO_W(32),
    .COMISION(1000), .LIMITE_RETIRO(500000), .TIMEOUT_CYC(TMO)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  atm_controller_param #(.PIN_DIGITS(4), .DIGIT_W(4), .MAX_INTENTOS(3), .BAL_W(16), .MONTO_W(16),
    .COMISION(1000), .LIMITE_RETIRO(500), .TIMEOUT_CYC(TMO)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  atm_controller_param #(.PIN_DIGITS(4), .DIGIT_W(4), .MAX_INTENTOS(3), .BAL_W(8), .MONTO_W(8),
    .COMISION(100), .LIMITE_RETIRO(200), .TIMEOUT_CYC(TMO)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  assign {ifa.tarjeta_recibida, ifb.tarjeta_recibida, ifc.tarjeta_recibida} = {3{card}};
  assign {ifa.tipo_de_tarjeta, ifb.tipo_de_tarjeta, ifc.tipo_de_tarjeta}    = {3{foreign}};
  assign {ifa.digito_stb, ifb.digito_stb, ifc.digito_stb}                   = {3{dstb}};
  assign {ifa.tipo_trans, ifb.tipo_trans, ifc.tipo_trans}                   = {3{tt}};
  assign {ifa.monto_stb, ifb.monto_stb, ifc.monto_stb}                      = {3{mstb}};
  assign {ifa.fin_sesion, ifb.fin_sesion, ifc.fin_sesion}                   = {3{fin}};
  assign {ifa.digito, ifb.digito, ifc.digito}                               = {3{dig}};
  assign {ifa.pin, ifb.pin, ifc.pin}                                        = {3{pin}};
  assign ifa.balance_carga = carga;
  assign ifb.balance_carga = carga[15:0];
  assign ifc.balance_carga = carga[7:0];
  assign ifa.monto = amt;
  assign ifb.monto = amt[15:0];
  assign ifc.monto = amt[7:0];

  logic [63:0] d_bal [3];
  logic [7:0]  d_fl  [3];
  assign d_bal[0] = ifa.balance_out;
  assign d_bal[1] = 64'(ifb.balance_out);
  assign d_bal[2] = 64'(ifc.balance_out);
  assign d_fl[0] = {ifa.balance_actualizado, ifa.entregar_dinero, ifa.fondos_insuficientes, ifa.limite_excedido,
                    ifa.pin_incorrecto, ifa.expulsar_tarjeta, ifa.advertencia, ifa.bloqueo};
  assign d_fl[1] = {ifb.balance_actualizado, ifb.entregar_dinero, ifb.fondos_insuficientes, ifb.limite_excedido,
                    ifb.pin_incorrecto, ifb.expulsar_tarjeta, ifb.advertencia, ifb.bloqueo};
  assign d_fl[2] = {ifc.balance_actualizado, ifc.entregar_dinero, ifc.fondos_insuficientes, ifc.limite_excedido,
                    ifc.pin_incorrecto, ifc.expulsar_tarjeta, ifc.advertencia, ifc.bloqueo};

  // Session model: balances as plain 64/65-bit arithmetic masked to each instance's width.
  typedef struct {
    int ph; int att; int nd; int ent; int idle;
    logic [63:0] bal; logic [63:0] wd; logic [63:0] amt;
    bit upd, dn, fi, le, pi, ej, adv, blk;
  } mdl_t;

  mdl_t m [3];
  int bw [3] = '{64, 16, 8};
  int mw [3] = '{32, 16, 8};
  longint unsigned com [3] = '{1000, 1000, 100};
  longint unsigned lim [3] = '{500000, 500, 200};

  function automatic logic [63:0] bmask(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic mdl_t step(input mdl_t s, input int k);
    mdl_t n = s;
    logic [64:0] sum;
    logic [63:0] mask, cg;
    mask = bmask(bw[k]);
    {n.upd, n.dn, n.fi, n.le, n.pi, n.ej} = '0;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    case (s.ph)
      P_CARD: if (card) begin
        cg = carga & mask;
        n.bal = cg;
        if (!foreign) n.ph = P_PIN;
        else if (cg >= com[k]) begin n.bal = cg - com[k]; n.ph = P_PIN; end
        else begin n.fi = 1; n.ej = 1; end
      end
      P_PIN: if (dstb) begin
        n.idle = 0;
        n.ent = s.ent * 16 + int'(dig);
        n.nd = s.nd + 1;
        if (n.nd == 4) begin
          if (n.ent == int'(pin)) begin n.ph = P_ID; n.att = 0; end
          else begin
            n.pi = 1; n.att = s.att + 1;
            if (n.att == 2) n.adv = 1;
            if (n.att == 3) begin n.ph = P_BLK; n.blk = 1; end
          end
          n.nd = 0; n.ent = 0;
        end
      end else if (mstb) n.idle = 0;
      else if (s.idle == TMO - 1) n.ph = P_FIN;
      else n.idle = s.idle + 1;
      P_ID: if (fin) n.ph = P_FIN;
      else if (mstb) begin n.amt = 64'(amt) & bmask(mw[k]); n.ph = tt ? P_RET : P_DEP; end
      else if (dstb) n.idle = 0;
      else if (s.idle == TMO - 1) n.ph = P_FIN;
      else n.idle = s.idle + 1;
      P_DEP: begin
        sum = {1'b0, s.bal} + {1'b0, s.amt};
        if (sum > {1'b0, mask}) sum = {1'b0, mask};
        n.bal = sum[63:0]; n.upd = 1; n.ph = P_ID;
      end
      P_RET: begin
        sum = {1'b0, s.wd} + {1'b0, s.amt};
        if (s.amt > s.bal) n.fi = 1;
        else if (sum > 65'(lim[k])) n.le = 1;
        else begin n.bal = s.bal - s.amt; n.wd = sum[63:0]; n.upd = 1; n.dn = (s.amt != 0); end
        n.ph = P_ID;
      end
      P_FIN: begin
        n.ej = 1; n.adv = 0; n.wd = 0; n.att = 0; n.nd = 0; n.ent = 0; n.ph = P_CARD;
      end
      default: ;
    endcase
    if (n.ph != s.ph) n.idle = 0;
    return n;
  endfunction

  always @(posedge clk) for (int k = 0; k < 3; k++) m[k] <= step(m[k], k);

  always @(negedge clk) if (cmp_en) begin
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (d_bal[k] !== m[k].bal) begin
        errors++;
        $display("FAIL bal[%0d] t=%0t got %0d expected %0d", k, $time, d_bal[k], m[k].bal);
      end
      if (d_fl[k] !== {m[k].upd, m[k].dn, m[k].fi, m[k].le, m[k].pi, m[k].ej, m[k].adv, m[k].blk}) begin
        errors++;
        $display("FAIL flags[%0d] t=%0t got %b expected %b", k, $time, d_fl[k],
                 {m[k].upd, m[k].dn, m[k].fi, m[k].le, m[k].pi, m[k].ej, m[k].adv, m[k].blk});
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert(input logic f, input logic [63:0] c);
    card = 1; foreign = f; carga = c;
    @(negedge clk);
    card = 0;
  endtask

  task automatic key(input logic [3:0] d);
    dig = d; dstb = 1;
    @(negedge clk);
    dstb = 0;
  endtask

  task automatic key_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) key(p[i*4 +: 4]);
  endtask

  task automatic trans(input logic t, input logic [31:0] a);
    tt = t; amt = a; mstb = 1;
    @(negedge clk);
    mstb = 0;
    @(negedge clk);
  endtask

  task automatic end_session();
    fin = 1;
    @(negedge clk);
    fin = 0;
    @(negedge clk);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt, n, g;
    reset = 1; card = 0; foreign = 0; carga = '0; dig = '0; dstb = 0; tt = 0; amt = '0; mstb = 0; fin = 0;
    pin = 16'h1234;
    cyc(2);
    cmp_en = 1;
    reset = 0;
    lit("reset_bal", d_bal[0], 0);
    lit("reset_flags", 64'(d_fl[0]), 0);

    insert(0, 5000);
    key_pin(16'h1234);
    trans(0, 300);
    lit("deposit_bal", d_bal[0], 5300);
    lit("deposit_upd", 64'(d_fl[0][F_UPD]), 1);
    cyc(1);
    lit("deposit_upd_one_cycle", 64'(d_fl[0][F_UPD]), 0);
    end_session();
    lit("fin_eject", 64'(d_fl[0][F_EJ]), 1);

    insert(1, 3000);
    lit("foreign_fee", d_bal[0], 2000);
    key_pin(16'h1234);
    trans(1, 2000);
    lit("withdraw_all_bal", d_bal[0], 0);
    lit("withdraw_all_dn", 64'(d_fl[0][F_DN]), 1);
    trans(1, 1);
    lit("withdraw_empty_fi", 64'(d_fl[0][F_FI]), 1);
    end_session();

    insert(0, 777);
    key_pin(16'h1111);
    lit("wrong1_pi", 64'(d_fl[0][F_PI]), 1);
    lit("wrong1_adv", 64'(d_fl[0][F_ADV]), 0);
    key_pin(16'h2222);
    lit("wrong2_adv", 64'(d_fl[0][F_ADV]), 1);
    key_pin(16'h3333);
    lit("wrong3_blk", 64'(d_fl[0][F_BLK]), 1);
    key_pin(16'h1234);
    trans(0, 5);
    lit("blocked_bal", d_bal[0], 777);
    lit("blocked_stays", 64'(d_fl[0][F_BLK]), 1);
    reset = 1;
    cyc(1);
    reset = 0;
    lit("reset_from_block", 64'(d_fl[0]), 0);

    insert(0, 10000);
    key_pin(16'h1234);
    trans(1, 400);
    lit("limit_ok_bal", d_bal[1], 9600);
    trans(1, 200);
    lit("limit_le", 64'(d_fl[1][F_LE]), 1);
    lit("limit_bal_kept", d_bal[1], 9600);
    end_session();

    insert(0, 50);
    key_pin(16'h1234);
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      cnt = i;
      if (d_fl[0][F_EJ]) break;
    end
    lit("timeout_cycles", 64'(cnt), 41);

    insert(0, 500);
    key_pin(16'h1234);
    fin = 1; mstb = 1; tt = 1; amt = 100;
    @(negedge clk);
    fin = 0; mstb = 0;
    @(negedge clk);
    lit("fin_wins_ej", 64'(d_fl[0][F_EJ]), 1);
    lit("fin_wins_bal", d_bal[0], 500);

    insert(0, 250);
    key_pin(16'h1234);
    trans(0, 10);
    lit("saturate_c", d_bal[2], 255);
    lit("no_saturate_a", d_bal[0], 260);
    end_session();

    insert(1, 50);
    lit("reject_fi", 64'(d_fl[2][F_FI]), 1);
    lit("reject_ej", 64'(d_fl[2][F_EJ]), 1);
    cyc(2);

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1;
        cyc(1);
        reset = 0;
      end
      insert(1'($urandom_range(0, 1)), 64'($urandom_range(0, 20000)));
      if ($urandom_range(0, 3) == 0) key_pin(16'($urandom()));
      else key_pin(16'h1234);
      n = $urandom_range(1, 6);
      for (int t = 0; t < n; t++) begin
        g = ($urandom_range(0, 9) == 0) ? TMO + 5 : $urandom_range(0, 3);
        for (int c = 0; c < g; c++) begin
          dstb = ($urandom_range(0, 15) == 0);
          dig = 4'($urandom());
          @(negedge clk);
          dstb = 0;
        end
        trans(1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 6000)));
      end
      if ($urandom_range(0, 1) == 1) end_session();
      cyc(2);
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
